// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Burst locking is compiled in only when MEM_ARB_BURST_LOCK_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOCK  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 5;
    localparam int DEF_MAX_BURST = 4;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked round-robin picker: lowest request strictly above ptr,
// falling back to the lowest request overall when nothing lies above it.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = idx_width(DEF_NUM_REQ)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [N-1:0] above;
    logic [N-1:0] cand;
    logic         hit;

    always_comb begin
        above  = '0;
        cand   = '0;
        onehot = '0;
        idx    = '0;
        hit    = 1'b0;
        for (int i = 0; i < N; i++) begin
            above[i] = (i > int'(ptr));
        end
        cand = ((req & above) != '0) ? (req & above) : req;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && !hit) begin
                onehot[i] = 1'b1;
                idx       = IW'(i);
                hit       = 1'b1;
            end
        end
    end

    assign found = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one memory bank to NUM_REQ requesters.
// Define MEM_ARB_BURST_LOCK_EN to enable locked bursts of up to MAX_BURST beats.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic                          mem_ready,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [idx_width(NUM_REQ)-1:0] gnt_idx,
    output logic                          gnt_valid,
    output logic [NUM_REQ-1:0]            pop,
    output arb_state_t                    fsm_state
);

    localparam int IW = idx_width(NUM_REQ);

    arb_state_t        state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      gnt_idx_q, idx_d;
    logic [IW-1:0]      ptr_q, ptr_d;

    logic               transfer;
    logic               req_held;
    logic               rearb;
    logic [IW-1:0]      pick_ptr;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;

`ifdef MEM_ARB_BURST_LOCK_EN
    localparam int            CW          = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LAST  = CW'(MAX_BURST - 1);
    localparam bit            BURST_MULTI = (MAX_BURST > 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_held;

    assign lock_held = |(gnt_q & lock);
`else
    localparam int unused_max_burst = MAX_BURST;
    logic          unused_lock;

    assign unused_lock = ^lock;
`endif

    assign transfer = (|gnt_q) & mem_ready;
    assign req_held = |(gnt_q & req);
    // After a transfer the just-served index becomes the mask origin in the same edge.
    assign pick_ptr = transfer ? gnt_idx_q : ptr_q;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = gnt_idx_q;
        ptr_d   = ptr_q;
        rearb   = 1'b0;
`ifdef MEM_ARB_BURST_LOCK_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                rearb = 1'b1;
            end
            ST_GRANT: begin
                if (transfer) begin
                    ptr_d = gnt_idx_q;
`ifdef MEM_ARB_BURST_LOCK_EN
                    if (BURST_MULTI && lock_held && req_held) begin
                        state_d = ST_LOCK;
                        cnt_d   = CW'(1);
                    end else begin
                        rearb = 1'b1;
                    end
`else
                    rearb = 1'b1;
`endif
                end else if (!req_held) begin
                    rearb = 1'b1;
                end
            end
`ifdef MEM_ARB_BURST_LOCK_EN
            ST_LOCK: begin
                if (transfer) begin
                    ptr_d = gnt_idx_q;
                    if (lock_held && req_held && (cnt_q < BURST_LAST)) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        rearb = 1'b1;
                    end
                end else if (!req_held) begin
                    rearb = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Re-arbitration lands in the same edge, so back-to-back grants have no bubble.
        if (rearb) begin
            gnt_d   = pick_onehot;
            idx_d   = pick_found ? pick_idx : '0;
            state_d = pick_found ? ST_GRANT : ST_IDLE;
`ifdef MEM_ARB_BURST_LOCK_EN
            cnt_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= IW'(NUM_REQ - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= idx_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef MEM_ARB_BURST_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;
    assign pop       = gnt_q & {NUM_REQ{mem_ready}};
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random run
// against a transaction-level round-robin model with a starvation bound.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 5;
    localparam int MB = 4;
`ifdef MEM_ARB_BURST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic         mem_ready;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_idx;
    logic         gnt_valid;
    logic [N-1:0] pop;
    arb_state_t   fsm_state;

    int tests = 0;
    int fails = 0;

    // Model: current holder (-1 idle), last-served index, beats taken by holder.
    int m_idx;
    int m_ptr;
    int m_beats;
    int waits[N];

    mem_port_arbiter #(
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .mem_ready (mem_ready),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .pop       (pop),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        lock      = '0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_idx   = -1;
        m_ptr   = N - 1;
        m_beats = 0;
        for (int j = 0; j < N; j++) waits[j] = 0;
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_gnt(input int idx);
        logic [N-1:0] g;
        g = '0;
        if (idx >= 0) g[idx] = 1'b1;
        return g;
    endfunction

    // Advance the model by one rising edge given the inputs applied this cycle.
    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
        bit keep;
        if (m_idx < 0) begin
            m_idx   = model_pick(r, m_ptr);
            m_beats = 0;
        end else if (rdy) begin
            m_ptr   = m_idx;
            m_beats = m_beats + 1;
            keep    = LOCK_EN && l[m_idx] && r[m_idx] && (m_beats < MB);
            if (!keep) begin
                m_idx   = model_pick(r, m_ptr);
                m_beats = 0;
            end
        end else if (!r[m_idx]) begin
            m_idx   = model_pick(r, m_ptr);
            m_beats = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (gnt !== '0) begin fails++; $display("FAIL reset_gnt: got %b want %b", gnt, 5'b0); end
        tests++;
        if (gnt_idx !== 3'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", gnt_idx); end
        tests++;
        if (gnt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        tests++;
        if (fsm_state !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp_g [4];
        logic [2:0]   exp_i [4];
        exp_g = '{5'b00010, 5'b00100, 5'b10000, 5'b00010};
        exp_i = '{3'd1, 3'd2, 3'd4, 3'd1};
        do_reset();
        req       = 5'b10110;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (gnt !== exp_g[i] || gnt_idx !== exp_i[i] || gnt_valid !== 1'b1) begin
                fails++;
                $display("FAIL rotation[%0d]: gnt=%b idx=%0d valid=%b want gnt=%b idx=%0d valid=1",
                         i, gnt, gnt_idx, gnt_valid, exp_g[i], exp_i[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        req       = 5'b00001;
        mem_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            tests++;
            if (gnt !== 5'b00001 || pop !== 5'b00000) begin
                fails++;
                $display("FAIL stall_cycle%0d: gnt=%b pop=%b want gnt=00001 pop=00000", c, gnt, pop);
            end
        end
        mem_ready = 1'b1;
        #1;
        tests++;
        if (gnt !== 5'b00001 || pop !== 5'b00001) begin
            fails++;
            $display("FAIL stall_cycle4: gnt=%b pop=%b want gnt=00001 pop=00001", gnt, pop);
        end
        req = '0;
        step();
        tests++;
        if (gnt !== 5'b00000 || pop !== 5'b00000) begin
            fails++;
            $display("FAIL stall_release: gnt=%b pop=%b want 00000/00000", gnt, pop);
        end
    endtask

    task automatic test_burst();
        logic [N-1:0] exp_g [6];
        if (LOCK_EN) exp_g = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00010, 5'b00001};
        else         exp_g = '{5'b00001, 5'b00010, 5'b00001, 5'b00010, 5'b00001, 5'b00010};
        do_reset();
        req       = 5'b00011;
        lock      = 5'b00001;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (gnt !== exp_g[i]) begin
                fails++;
                $display("FAIL burst[%0d]: gnt=%b want %b", i, gnt, exp_g[i]);
            end
            if (i == 1) begin
                tests++;
                if (fsm_state !== (LOCK_EN ? ST_LOCK : ST_GRANT)) begin
                    fails++;
                    $display("FAIL burst_state: got %0d want %0d", fsm_state, LOCK_EN ? ST_LOCK : ST_GRANT);
                end
            end
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req       = 5'b00010;
        mem_ready = 1'b1;
        step();
        req = 5'b00100;
        step();
        mem_ready = 1'b0;
        step();
        tests++;
        if (gnt !== 5'b00100) begin fails++; $display("FAIL withdraw_hold: gnt=%b want 00100", gnt); end
        req = 5'b10000;
        step();
        tests++;
        if (gnt !== 5'b10000 || gnt_idx !== 3'd4) begin
            fails++;
            $display("FAIL withdraw_regrant: gnt=%b idx=%0d want 10000 idx=4", gnt, gnt_idx);
        end
        // Pointer must still be 1, so index 2 beats index 0.
        req = 5'b00101;
        step();
        tests++;
        if (gnt !== 5'b00100) begin fails++; $display("FAIL withdraw_pointer: gnt=%b want 00100", gnt); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req       = 5'b00011;
        lock      = 5'b00001;
        mem_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        tests++;
        if (gnt !== '0 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || pop !== '0) begin
            fails++;
            $display("FAIL async_reset: gnt=%b valid=%b idx=%0d pop=%b want all zero", gnt, gnt_valid, gnt_idx, pop);
        end
        tests++;
        if (fsm_state !== ST_IDLE) begin fails++; $display("FAIL async_reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        req  = 5'b11111;
        lock = '0;
        step();
        tests++;
        if (gnt !== 5'b00001) begin fails++; $display("FAIL post_reset_grant: gnt=%b want 00001", gnt); end
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        int           xfer;
        do_reset();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            for (int j = 0; j < N; j++) begin
                if (req[j]) begin
                    if ($urandom_range(0, 7) == 0) req[j] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[j] = 1'b1;
                end
                lock[j] = ($urandom_range(0, 9) < 6);
            end
            mem_ready = ($urandom_range(0, 9) < 7);
            #1;
            eg = model_gnt(m_idx);
            tests++;
            if (gnt !== eg || gnt_idx !== 3'((m_idx < 0) ? 0 : m_idx) || pop !== (eg & {N{mem_ready}})) begin
                fails++;
                $display("FAIL random_cyc%0d: gnt=%b idx=%0d pop=%b want gnt=%b idx=%0d pop=%b",
                         cyc, gnt, gnt_idx, pop, eg, (m_idx < 0) ? 0 : m_idx, eg & {N{mem_ready}});
            end
            tests++;
            if (!$onehot0(gnt) || gnt_valid !== (gnt != '0)) begin
                fails++;
                $display("FAIL random_onehot%0d: gnt=%b valid=%b want one-hot-or-zero", cyc, gnt, gnt_valid);
            end
            xfer = (m_idx >= 0 && mem_ready) ? m_idx : -1;
            model_step(req, lock, mem_ready);
            for (int j = 0; j < N; j++) begin
                if (!req[j] || xfer == j) begin
                    waits[j] = 0;
                end else if (xfer >= 0) begin
                    waits[j]++;
                    tests++;
                    if (waits[j] > (N - 1) * MB) begin
                        fails++;
                        $display("FAIL starvation req%0d: waited %0d transfers, limit %0d", j, waits[j], (N - 1) * MB);
                    end
                end
            end
            step();
        end
    endtask

    initial begin
        rst       = 1'b0;
        req       = '0;
        lock      = '0;
        mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_stall();
        test_burst();
        test_withdraw();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
